heap_cmd_issue: RTL and testbench
=================================

Name: heap_cmd_issue

Overview:
- Front-end stage upstream of the custom-instruction heap unit.
- Accepts heap instruction requests (push/pop/size) from the core dispatch, buffers them in a small command FIFO and issues one push or pop strobe at a time when the heap is idle.
- Tracks heap occupancy locally and rejects illegal ops (push-when-full, pop-when-empty) without touching the heap.
- Returns one tagged response per command (rd, data, error) to the writeback path, with backpressure.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- HEAP_SIZE, 25, heap capacity; must match the heap unit.
- CNT_W, $clog2(HEAP_SIZE+1), occupancy counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_v  in  1  command valid.
- in_ready  out  1  command accepted when in_v && in_ready.
- in_op  in  2  00=push, 01=pop, 10=size, 11=reserved (treated as error).
- in_rd  in  5  destination register tag.
- in_data  in  32  push operand; only [7:0] is used.
- heap_push  out  1  one-cycle push strobe to the heap.
- heap_pop  out  1  one-cycle pop strobe to the heap.
- heap_wdata  out  32  push data, {24'd0, byte}.
- heap_busy  in  1  high while the heap FSM is not IDLE.
- heap_rdata  in  8  heap pop output register.
- resp_v  out  1  response valid.
- resp_ready  in  1  response accepted.
- resp_rd  out  5  echoed tag.
- resp_data  out  32  response payload.
- resp_err  out  1  command rejected.
- heap_count  out  CNT_W  local occupancy.

Behaviour:
- Reset (async): FIFO empty, state=IDLE, heap_count=0, all strobes 0, resp_v=0, resp_rd=0, resp_data=0, resp_err=0, in_ready=1. Reset mid-command drops everything and emits no response. The heap shares the same reset.
- FIFO:
  - in_ready = !fifo_full.
  - Enqueue on in_v && in_ready; pointers wrap modulo CMD_DEPTH.
  - Dequeue happens only on the IDLE->ISSUE or IDLE->RESP transition.
  - Enqueue and dequeue in the same cycle are allowed; occupancy is unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE, FIFO non-empty and !heap_busy, head op evaluated:
    - push with heap_count==HEAP_SIZE -> RESP, err=1, data=0.
    - pop with heap_count==0 -> RESP, err=1, data=0.
    - op 11 -> RESP, err=1, data=0.
    - size -> RESP, err=0, data={zero-extended heap_count}. No heap access.
    - otherwise -> ISSUE; latch op, rd and data.
  - IDLE with an empty FIFO or heap_busy high: hold.
  - ISSUE (exactly 1 cycle):
    - heap_push or heap_pop = 1; heap_wdata = {24'd0, data[7:0]}.
    - heap_count +1 (push) or -1 (pop) at the end of the cycle.
    - -> WAIT.
  - WAIT:
    - Lasts at least 1 cycle.
    - Exit when heap_busy==0 -> RESP.
    - On exit, pop captures resp_data={24'd0, heap_rdata}; push sets resp_data={zero-extended new heap_count}.
    - resp_err=0.
  - RESP:
    - resp_v=1; resp_rd/data/err held stable until resp_ready.
    - On resp_v && resp_ready -> IDLE.
    - resp_v returns to 0 the next cycle unless IDLE immediately produces a new response.
- Strobes are registered, are never asserted outside ISSUE, and heap_push and heap_pop are never asserted together.
- Latency, command accepted at edge N with heap idle and resp_ready=1:
  - heap strobe high in cycle N+2.
  - Earliest resp_v in cycle N+4 (WAIT exits at the first sample of heap_busy low).
  - Rejected or size commands: resp_v in cycle N+2.
- Ordering: responses return strictly in command order; at most one command is in flight.
- heap_count never exceeds HEAP_SIZE and never underflows.

Test Plan:
- Push 10, 50, 30 (rd=1,2,3), then pop rd=4 -> three push responses with data 1, 2, 3 and err=0; pop response rd=4, data=50, heap_count=2.
- Pop after reset, rd=7 -> resp_v in cycle N+2, rd=7, err=1, data=0; heap_pop never asserted; heap_count=0.
- Push 25 values, then a 26th push -> 26th response err=1; heap_push pulse count=25; heap_count stays 25; a following size op returns 25.
- Hold heap_busy=1 and issue 6 back-to-back commands -> exactly 4 accepted, in_ready=0 afterwards; no strobes; after releasing heap_busy all 4 complete in order.
- resp_ready=0 for 5 cycles during a pop response -> resp_v, rd and data held stable; no new strobe issued; completes on the first resp_ready.
- Assert reset during WAIT of a pop -> all outputs return to reset values immediately; no response for the in-flight command; the next push completes with data 1.

Source files
------------

// File: rtl/heap_cmd_issue.sv
// Command front-end for the heap unit: buffers push/pop/size requests, issues one heap
// strobe at a time, tracks occupancy locally and returns one tagged response per command.
module heap_cmd_issue #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned HEAP_SIZE = 25,
    parameter int unsigned CNT_W     = $clog2(HEAP_SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_v,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_data,
    output logic             heap_push,
    output logic             heap_pop,
    output logic [31:0]      heap_wdata,
    input  logic             heap_busy,
    input  logic [7:0]       heap_rdata,
    output logic             resp_v,
    input  logic             resp_ready,
    output logic [4:0]       resp_rd,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic [CNT_W-1:0] heap_count
);

    localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
    localparam int unsigned FILL_W = $clog2(CMD_DEPTH + 1);

    localparam logic [1:0] OpPush = 2'b00;
    localparam logic [1:0] OpPop  = 2'b01;
    localparam logic [1:0] OpSize = 2'b10;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    // Command FIFO; only the low operand byte is ever forwarded to the heap.
    logic [1:0]        fifo_op   [CMD_DEPTH];
    logic [4:0]        fifo_rd   [CMD_DEPTH];
    logic [7:0]        fifo_data [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic              fifo_empty, enq, deq;
    logic [1:0]        head_op;
    logic [4:0]        head_rd;
    logic [7:0]        head_data;
    logic              unused_data;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_q, push_d, pop_q, pop_d;
    logic [4:0]       resp_rd_q, resp_rd_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    assign unused_data = ^in_data[31:8];
    assign fifo_empty  = (fill_q == '0);
    assign in_ready    = (fill_q != FILL_W'(CMD_DEPTH));
    assign enq         = in_v && in_ready;
    assign head_op     = fifo_op[rd_ptr_q];
    assign head_rd     = fifo_rd[rd_ptr_q];
    assign head_data   = fifo_data[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_op[wr_ptr_q]   <= in_op;
            fifo_rd[wr_ptr_q]   <= in_rd;
            fifo_data[wr_ptr_q] <= in_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (enq && !deq) begin
                fill_q <= fill_q + FILL_W'(1);
            end else if (deq && !enq) begin
                fill_q <= fill_q - FILL_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        deq         = 1'b0;
        op_d        = op_q;
        rd_d        = rd_q;
        data_d      = data_q;
        count_d     = count_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        resp_rd_d   = resp_rd_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && !heap_busy) begin
                    deq = 1'b1;
                    if (head_op == OpPush && count_q != CNT_W'(HEAP_SIZE)) begin
                        state_d = StIssue;
                        push_d  = 1'b1;
                    end else if (head_op == OpPop && count_q != '0) begin
                        state_d = StIssue;
                        pop_d   = 1'b1;
                    end else begin
                        // Rejected ops and size queries answer without touching the heap.
                        state_d     = StResp;
                        resp_rd_d   = head_rd;
                        resp_err_d  = (head_op != OpSize);
                        resp_data_d = (head_op == OpSize) ? 32'(count_q) : 32'd0;
                    end
                    op_d   = head_op;
                    rd_d   = head_rd;
                    data_d = head_data;
                end
            end
            StIssue: begin
                state_d = StWait;
                count_d = (op_q == OpPush) ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
            end
            StWait: begin
                if (!heap_busy) begin
                    state_d     = StResp;
                    resp_rd_d   = rd_q;
                    resp_err_d  = 1'b0;
                    resp_data_d = (op_q == OpPop) ? {24'd0, heap_rdata} : 32'(count_q);
                end
            end
            default: begin
                if (resp_ready) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            count_q     <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            count_q     <= count_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            resp_rd_q   <= resp_rd_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign heap_push  = push_q;
    assign heap_pop   = pop_q;
    assign heap_wdata = {24'd0, data_q};
    assign resp_v     = (state_q == StResp);
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign heap_count = count_q;

endmodule

// File: tb/tb_heap_cmd_issue.sv
// Bench for heap_cmd_issue: behavioural max-heap, response scoreboard, vector table plus
// hand-written latency, fill, backpressure, busy-hold and reset corner cases.
module tb_heap_cmd_issue;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_v;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [4:0]       in_rd;
    logic [31:0]      in_data;
    logic             heap_push;
    logic             heap_pop;
    logic [31:0]      heap_wdata;
    logic             heap_busy;
    logic [7:0]       heap_rdata;
    logic             resp_v;
    logic             resp_ready;
    logic [4:0]       resp_rd;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic [CNT_W-1:0] heap_count;

    heap_cmd_issue dut (
        .clk        (clk),
        .reset      (reset),
        .in_v       (in_v),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .heap_push  (heap_push),
        .heap_pop   (heap_pop),
        .heap_wdata (heap_wdata),
        .heap_busy  (heap_busy),
        .heap_rdata (heap_rdata),
        .resp_v     (resp_v),
        .resp_ready (resp_ready),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .heap_count (heap_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    resp_t exp_q[$];
    resp_t got;

    // Behavioural max-heap: busy for busy_len cycles after each strobe.
    int   hq[$];
    int   busy_len = 2;
    int   busy_left;
    int   push_pulses;
    int   pop_pulses;
    logic model_busy;
    logic force_busy;

    assign heap_busy = model_busy || force_busy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hq.delete();
            busy_left   = 0;
            push_pulses = 0;
            pop_pulses  = 0;
            model_busy <= 1'b0;
            heap_rdata <= 8'd0;
        end else begin
            if (heap_push) begin
                hq.push_back(int'(heap_wdata[7:0]));
                push_pulses++;
            end
            if (heap_pop && hq.size() > 0) begin : pop_blk
                int mi;
                mi = 0;
                for (int i = 1; i < hq.size(); i++) if (hq[i] > hq[mi]) mi = i;
                heap_rdata <= 8'(hq[mi]);
                hq.delete(mi);
                pop_pulses++;
            end
            if (heap_push || heap_pop) busy_left = busy_len;
            else if (busy_left > 0) busy_left--;
            model_busy <= (busy_left > 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (heap_push || heap_pop) begin
                check("strobe_excl", 32'(heap_push & heap_pop), 32'd0);
                if (heap_push) check("wdata_upper", 32'(heap_wdata[31:8]), 32'd0);
            end
            if (resp_v && resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got rd=%0d err=%0b data=%0h expected none",
                             resp_rd, resp_err, resp_data);
                end else begin
                    got = exp_q.pop_front();
                    if ({resp_rd, resp_err, resp_data} !== got) begin
                        errors++;
                        $display("FAIL resp: got rd=%0d err=%0b data=%0h expected rd=%0d err=%0b data=%0h",
                                 resp_rd, resp_err, resp_data, got.rd, got.err, got.data);
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] d,
                        input logic eerr, input logic [31:0] edata);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_v = 1'b1; in_op = op; in_rd = rd; in_data = d;
            exp_q.push_back('{rd: rd, err: eerr, data: edata});
            @(negedge clk);
            in_v = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_v = 1'b0; force_busy = 1'b0; resp_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[10];
    vec_t bv[6];
    int   accepted;
    int   n;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 5'd1,  32'hABCD_000A, 1'b0, 32'd1};
        vecs[1] = '{2'b00, 5'd2,  32'd50,        1'b0, 32'd2};
        vecs[2] = '{2'b00, 5'd3,  32'd30,        1'b0, 32'd3};
        vecs[3] = '{2'b01, 5'd4,  32'd0,         1'b0, 32'd50};
        vecs[4] = '{2'b10, 5'd5,  32'd0,         1'b0, 32'd2};
        vecs[5] = '{2'b11, 5'd6,  32'd9,         1'b1, 32'd0};
        vecs[6] = '{2'b01, 5'd7,  32'd0,         1'b0, 32'd30};
        vecs[7] = '{2'b01, 5'd8,  32'd0,         1'b0, 32'd10};
        vecs[8] = '{2'b01, 5'd9,  32'd0,         1'b1, 32'd0};
        vecs[9] = '{2'b10, 5'd10, 32'd0,         1'b0, 32'd0};
        bv[0] = '{2'b00, 5'd1, 32'd5, 1'b0, 32'd1};
        bv[1] = '{2'b00, 5'd2, 32'd9, 1'b0, 32'd2};
        bv[2] = '{2'b01, 5'd3, 32'd0, 1'b0, 32'd9};
        bv[3] = '{2'b10, 5'd4, 32'd0, 1'b0, 32'd1};
        bv[4] = '{2'b00, 5'd5, 32'd7, 1'b0, 32'd0};
        bv[5] = '{2'b00, 5'd6, 32'd8, 1'b0, 32'd0};

        reset = 1'b1; in_v = 1'b0; in_op = 2'b00; in_rd = 5'd0; in_data = 32'd0;
        resp_ready = 1'b1; force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_resp_v", 32'(resp_v), 32'd0);
        check("rst_strobes", 32'({heap_push, heap_pop}), 32'd0);
        check("rst_count", 32'(heap_count), 32'd0);
        check("rst_resp_fields", 32'(resp_rd) | resp_data | 32'(resp_err), 32'd0);
        reset = 1'b0;

        // Rejected pop on empty heap answers in N+2.
        @(negedge clk);
        in_v = 1'b1; in_op = 2'b01; in_rd = 5'd7; in_data = 32'd0;
        exp_q.push_back('{rd: 5'd7, err: 1'b1, data: 32'd0});
        @(negedge clk);
        in_v = 1'b0;
        check("rej_lat_n1", 32'(resp_v), 32'd0);
        @(negedge clk);
        check("rej_lat_n2", 32'(resp_v), 32'd1);
        check("rej_rd", 32'(resp_rd), 32'd7);
        drain();
        check("rej_no_pop", 32'(pop_pulses), 32'd0);
        check("rej_count", 32'(heap_count), 32'd0);

        // Push latency with an always-idle heap.
        busy_len = 0;
        @(negedge clk);
        in_v = 1'b1; in_op = 2'b00; in_rd = 5'd1; in_data = 32'hDEAD_BE34;
        exp_q.push_back('{rd: 5'd1, err: 1'b0, data: 32'd1});
        @(negedge clk);
        in_v = 1'b0;
        check("push_lat_n1", 32'(heap_push), 32'd0);
        @(negedge clk);
        check("push_lat_n2", 32'(heap_push), 32'd1);
        check("push_wdata", heap_wdata, 32'h34);
        @(negedge clk);
        check("push_lat_n3", 32'({heap_push, resp_v}), 32'd0);
        @(negedge clk);
        check("push_lat_n4", 32'(resp_v), 32'd1);
        check("push_lat_count", 32'(heap_count), 32'd1);
        drain();

        // Vector table.
        do_reset();
        busy_len = 2;
        foreach (vecs[i]) send(vecs[i].op, vecs[i].rd, vecs[i].data, vecs[i].err, vecs[i].exp);
        drain();
        check("table_count", 32'(heap_count), 32'd0);

        // Fill to capacity, overflow, size.
        do_reset();
        busy_len = 1;
        for (int i = 0; i < 25; i++) send(2'b00, 5'(i), 32'(i + 100), 1'b0, 32'(i + 1));
        send(2'b00, 5'd26, 32'd200, 1'b1, 32'd0);
        send(2'b10, 5'd27, 32'd0, 1'b0, 32'd25);
        drain();
        check("full_push_pulses", 32'(push_pulses), 32'd25);
        check("full_count", 32'(heap_count), 32'd25);

        // Heap busy: FIFO fills to 4, nothing issues.
        do_reset();
        force_busy = 1'b1;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_v = 1'b1; in_op = bv[i].op; in_rd = bv[i].rd; in_data = bv[i].data;
            if (in_ready) begin
                accepted++;
                exp_q.push_back('{rd: bv[i].rd, err: bv[i].err, data: bv[i].exp});
            end
        end
        @(negedge clk);
        in_v = 1'b0;
        check("busy_accepted", 32'(accepted), 32'd4);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("busy_no_strobe", 32'(push_pulses + pop_pulses), 32'd0);
        force_busy = 1'b0;
        drain();

        // Response backpressure on a pop.
        do_reset();
        busy_len = 1;
        send(2'b00, 5'd1, 32'd42, 1'b0, 32'd1);
        drain();
        @(posedge clk);
        #1 resp_ready = 1'b0;
        send(2'b01, 5'd2, 32'd0, 1'b0, 32'd42);
        n = 0;
        while (!resp_v && n < 50) begin
            @(negedge clk);
            n++;
        end
        send(2'b00, 5'd3, 32'd11, 1'b0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_v", 32'(resp_v), 32'd1);
            check("bp_hold", {resp_data[26:0], resp_rd}, {27'd42, 5'd2});
        end
        check("bp_no_strobe", 32'(push_pulses * 16 + pop_pulses), 32'd17);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

        // Reset while a pop waits on the heap.
        do_reset();
        busy_len = 4;
        send(2'b00, 5'd1, 32'd77, 1'b0, 32'd1);
        send(2'b00, 5'd2, 32'd88, 1'b0, 32'd2);
        drain();
        send(2'b01, 5'd4, 32'd0, 1'b0, 32'd88);
        n = 0;
        while (!heap_pop && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("wrst_count", 32'(heap_count), 32'd0);
        check("wrst_resp", {resp_data[25:0], resp_rd, resp_v}, 32'd0);
        check("wrst_ready", 32'(in_ready), 32'd1);
        check("wrst_strobes", 32'({heap_push, heap_pop, resp_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        busy_len = 2;
        send(2'b00, 5'd3, 32'd5, 1'b0, 32'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
